// File: rtl/bilinear_pe_if.sv
// Pixel stream interface for the bilinear interpolation stage.
// Carries the four neighbour pixels and the fractional offsets in, and the
// interpolated pixel out. The master drives the neighbour pixels and
// OUT_READY. The slave, which is the PE, drives IN_READY and the result.
//
// Handshake semantics (both directions): a beat transfers on a rising clk
// edge where VALID && READY. While VALID is high and READY is low, the
// sender holds VALID and its payload stable. VALID never depends
// combinationally on READY. READY may depend combinationally on the
// receiver's state and on the opposite-side READY.
interface bilinear_pe_if #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] P00;
    logic [DATA_W-1:0] P10;
    logic [DATA_W-1:0] P01;
    logic [DATA_W-1:0] P11;
    logic [FRAC_W-1:0] FX;
    logic [FRAC_W-1:0] FY;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] O_DATA;
    logic              OUT_LAST;

    modport master (
        output IN_VALID, P00, P10, P01, P11, FX, FY, OUT_READY,
        input  IN_READY, OUT_VALID, O_DATA, OUT_LAST
    );

    modport slave (
        input  IN_VALID, P00, P10, P01, P11, FX, FY, OUT_READY,
        output IN_READY, OUT_VALID, O_DATA, OUT_LAST
    );
endinterface

// File: rtl/bilinear_pe.sv
// Bilinear interpolation processing element: a three-stage pipeline with a
// single global stall. The stages are the horizontal blend, the vertical
// blend, and the normalisation shift. The PE also counts output pixels per
// frame, flags the last pixel and pulses DONE when a frame completes.
// Optional build macro BILERP_ROUND_EN: when it is defined, the last stage
// rounds half-up. When it is undefined, the last stage truncates.
module bilinear_pe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int DIM_W  = 7
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             START,
    input  logic [DIM_W-1:0] OUT_W,
    input  logic [DIM_W-1:0] OUT_H,
    output logic             DONE,
    bilinear_pe_if.slave     bus
);
    localparam int TW = DATA_W + FRAC_W;    // one-axis blend width
    localparam int VW = DATA_W + 2*FRAC_W;  // two-axis blend width
    localparam int CW = 2*DIM_W;            // pixel counter width
    localparam logic [FRAC_W:0] W_ONE = {1'b1, {FRAC_W{1'b0}}};
`ifdef BILERP_ROUND_EN
    localparam logic [VW-1:0] RND = VW'(1) << (2*FRAC_W - 1);
`endif

    logic              advance;
    logic              in_hs;
    logic              out_hs;
    logic              out_last;

    logic [FRAC_W:0]   wx0_c;
    logic [FRAC_W:0]   wy0_c;
    logic [TW-1:0]     top_c;
    logic [TW-1:0]     bot_c;
    logic [VW-1:0]     v_c;
    logic [VW-1:0]     v_rnd_c;
    logic [DATA_W-1:0] pix_c;

    logic              s1_valid;
    logic [TW-1:0]     s1_top;
    logic [TW-1:0]     s1_bot;
    logic [FRAC_W:0]   s1_wy0;
    logic [FRAC_W-1:0] s1_fy;
    logic              s2_valid;
    logic [VW-1:0]     s2_v;
    logic              out_valid;
    logic [DATA_W-1:0] o_data;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     frame_total;
    logic [DIM_W-1:0]  w_lat;
    logic [DIM_W-1:0]  h_lat;
    logic              done_q;

    // The whole pipe moves together. It stalls only when a held result is
    // refused downstream.
    assign advance      = !out_valid || bus.OUT_READY;
    assign bus.IN_READY = advance && !START;
    assign in_hs        = bus.IN_VALID && bus.IN_READY;
    assign out_hs       = out_valid && bus.OUT_READY;

    // A zero-sized frame has no last pixel, so the compare is gated on a
    // non-zero product instead of relying on the wrapped value of total-1.
    assign frame_total = CW'(w_lat) * CW'(h_lat);
    assign out_last    = out_valid && (frame_total != '0) &&
                         (cnt == frame_total - CW'(1));

    assign bus.OUT_VALID = out_valid;
    assign bus.O_DATA    = o_data;
    assign bus.OUT_LAST  = out_last;
    assign DONE          = done_q;

    // Datapath for each stage: the weights, the two blends, and the final
    // normalisation.
    always_comb begin
        wx0_c = W_ONE - {1'b0, bus.FX};
        wy0_c = W_ONE - {1'b0, bus.FY};
        top_c = TW'(wx0_c) * TW'(bus.P00) + TW'(bus.FX) * TW'(bus.P10);
        bot_c = TW'(wx0_c) * TW'(bus.P01) + TW'(bus.FX) * TW'(bus.P11);
        v_c   = VW'(s1_wy0) * VW'(s1_top) + VW'(s1_fy) * VW'(s1_bot);
`ifdef BILERP_ROUND_EN
        v_rnd_c = s2_v + RND;
`else
        v_rnd_c = s2_v;
`endif
        // Largest V plus rounding still fits VW bits, and the shifted value
        // never exceeds the pixel maximum, so no clamp is needed.
        pix_c = DATA_W'(v_rnd_c >> (2*FRAC_W));
    end

    // Pipeline registers. START flushes the valids. Otherwise every stage
    // loads together on advance, so bubbles travel with the data.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_top    <= '0;
            s1_bot    <= '0;
            s1_wy0    <= '0;
            s1_fy     <= '0;
            s2_valid  <= 1'b0;
            s2_v      <= '0;
            out_valid <= 1'b0;
            o_data    <= '0;
        end else if (START) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_hs;
            s1_top    <= top_c;
            s1_bot    <= bot_c;
            s1_wy0    <= wy0_c;
            s1_fy     <= bus.FY;
            s2_valid  <= s1_valid;
            s2_v      <= v_c;
            out_valid <= s2_valid;
            o_data    <= pix_c;
        end
    end

    // Frame bookkeeping. START latches the frame size and restarts the
    // count. The last-pixel handshake wraps the counter and raises DONE
    // for one cycle.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            w_lat  <= '0;
            h_lat  <= '0;
            done_q <= 1'b0;
        end else if (START) begin
            cnt    <= '0;
            w_lat  <= OUT_W;
            h_lat  <= OUT_H;
            done_q <= 1'b0;
        end else begin
            done_q <= out_hs && out_last;
            if (out_hs) begin
                cnt <= out_last ? '0 : cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bilinear_pe.sv
// Self-checking bench for bilinear_pe.
// Expected {last, pixel} pairs are queued on every input handshake and are
// compared on every output handshake.
module tb_bilinear_pe;
    localparam int DATA_W = 8;
    localparam int FRAC_W = 4;
    localparam int DIM_W  = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DIM_W-1:0] out_w;
    logic [DIM_W-1:0] out_h;
    logic             done;

    bilinear_pe_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) bus ();

    bilinear_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .DIM_W(DIM_W)) dut (
        .clk   (clk),
        .RST_N (rst_n),
        .START (start),
        .OUT_W (out_w),
        .OUT_H (out_h),
        .DONE  (done),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int                checks = 0;
    int                passes = 0;
    logic [DATA_W:0]   exp_q[$];
    int                out_cnt  = 0;
    int                last_cnt = 0;
    int                done_cnt = 0;
    logic [2*DIM_W-1:0] m_total = '0;
    logic [2*DIM_W-1:0] m_idx   = '0;
    logic              done_exp = 1'b0;
    bit                rand_ready = 1'b0;

    // Reference value from the direct four-corner weighted sum.
    function automatic logic [DATA_W-1:0] model_pix(input logic [7:0] a, b, c, d,
                                                    input logic [3:0] fx, fy);
        int ia, ib, ic, id, ifx, ify, wx0, wy0, v;
        ia = a; ib = b; ic = c; id = d; ifx = fx; ify = fy;
        wx0 = 16 - ifx;
        wy0 = 16 - ify;
        v = wx0*wy0*ia + ifx*wy0*ib + wx0*ify*ic + ifx*ify*id;
`ifdef BILERP_ROUND_EN
        v = v + 128;
`endif
        return DATA_W'(v >> 8);
    endfunction

    // Monitor: the handshakes are evaluated mid-cycle, and each one takes
    // effect on the following rising edge.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        logic            lst;
        if (!rst_n) begin
            exp_q.delete();
            m_total  = '0;
            m_idx    = '0;
            done_exp = 1'b0;
        end else begin
            if (done || done_exp) begin
                checks++;
                if (done !== done_exp)
                    $display("FAIL done_pulse: DONE=%0b expected %0b at %0t", done, done_exp, $time);
                else
                    passes++;
            end
            if (done) done_cnt++;
            if (start) begin
                exp_q.delete();
                m_total  = (2*DIM_W)'(out_w) * (2*DIM_W)'(out_h);
                m_idx    = '0;
                done_exp = 1'b0;
            end else begin
                done_exp = 1'b0;
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    out_cnt++;
                    if (bus.OUT_LAST) last_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_output: got data=%0d last=%0b, expected nothing at %0t",
                                 bus.O_DATA, bus.OUT_LAST, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.OUT_LAST, bus.O_DATA} !== e)
                            $display("FAIL sb_output: got data=%0d last=%0b, expected data=%0d last=%0b at %0t",
                                     bus.O_DATA, bus.OUT_LAST, e[DATA_W-1:0], e[DATA_W], $time);
                        else
                            passes++;
                        done_exp = e[DATA_W];
                    end
                end
                if (bus.IN_VALID && bus.IN_READY) begin
                    lst = (m_total != '0) && (m_idx == m_total - (2*DIM_W)'(1));
                    exp_q.push_back({lst, model_pix(bus.P00, bus.P10, bus.P01, bus.P11, bus.FX, bus.FY)});
                    m_idx = lst ? '0 : m_idx + (2*DIM_W)'(1);
                end
            end
        end
    end

    // Random downstream backpressure, enabled only by the random test.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, b, c, d, input logic [3:0] fx, fy);
        bit hs;
        hs = 1'b0;
        bus.P00 = a; bus.P10 = b; bus.P01 = c; bus.P11 = d;
        bus.FX = fx; bus.FY = fy;
        bus.IN_VALID = 1'b1;
        for (int g = 0; g < 100 && !hs; g++) begin
            @(negedge clk);
            hs = bus.IN_READY;
            @(posedge clk);
            #1;
        end
        bus.IN_VALID = 1'b0;
        if (!hs) begin
            checks++;
            $display("FAIL send_timeout: IN_READY=0 for 100 cycles, required 1");
        end
    endtask

    task automatic do_start(input logic [DIM_W-1:0] w, h);
        out_w = w;
        out_h = h;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && bus.OUT_VALID == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", bus.OUT_VALID); else passes++;
        checks++; if (bus.O_DATA !== 8'd0) $display("FAIL reset_o_data: got %0d, required 0", bus.O_DATA); else passes++;
        checks++; if (bus.OUT_LAST !== 1'b0) $display("FAIL reset_out_last: got %0b, required 0", bus.OUT_LAST); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b, required 0", done); else passes++;
        rst_n = 1'b1;
        idle(1);
        checks++; if (bus.IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", bus.IN_READY); else passes++;
    endtask

    task automatic test_identity_latency;
        int n;
        send(8'd77, 8'd200, 8'd200, 8'd200, 4'd0, 4'd0);
        n = 1;
        while (!bus.OUT_VALID && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 3) $display("FAIL latency: got %0d cycles, required 3", n); else passes++;
        checks++; if (bus.O_DATA !== 8'd77) $display("FAIL identity: got %0d, required 77", bus.O_DATA); else passes++;
        idle(2);
    endtask

    task automatic test_vectors;
        logic [7:0] a_t[3], b_t[3], c_t[3], d_t[3], e_t[3];
        logic [3:0] fx_t[3], fy_t[3];
        int n;
        a_t = '{8'd0, 8'd10, 8'd255};
        b_t = '{8'd255, 8'd20, 8'd255};
        c_t = '{8'd0, 8'd30, 8'd255};
        d_t = '{8'd255, 8'd40, 8'd255};
        fx_t = '{4'd8, 4'd4, 4'd15};
        fy_t = '{4'd0, 4'd8, 4'd15};
`ifdef BILERP_ROUND_EN
        e_t = '{8'd128, 8'd23, 8'd255};
`else
        e_t = '{8'd127, 8'd22, 8'd255};
`endif
        for (int i = 0; i < 3; i++) begin
            send(a_t[i], b_t[i], c_t[i], d_t[i], fx_t[i], fy_t[i]);
            n = 0;
            while (!bus.OUT_VALID && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if ({bus.OUT_VALID, bus.O_DATA} !== {1'b1, e_t[i]})
                $display("FAIL vector_%0d: got valid=%0b data=%0d, required valid=1 data=%0d",
                         i, bus.OUT_VALID, bus.O_DATA, e_t[i]);
            else
                passes++;
            idle(1);
        end
    endtask

    task automatic test_back_to_back;
        time t0;
        int  c0;
        bit  ok;
        c0 = out_cnt;
        t0 = $time;
        for (int i = 0; i < 8; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        checks++; if ($time - t0 !== 80) $display("FAIL throughput: 8 inputs took %0t, required 80", $time - t0); else passes++;
        wait_drain(ok);
        checks++; if (!ok || out_cnt - c0 !== 8) $display("FAIL b2b_count: got %0d outputs, required 8", out_cnt - c0); else passes++;
    endtask

    task automatic test_backpressure;
        int  c0;
        bit  ok;
        c0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(40 + 7*i), 8'd0, 8'd0, 8'd0, 4'd0, 4'd0);
            end
            begin
                int n;
                logic [7:0] held;
                n = 0;
                while (!bus.OUT_VALID && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                bus.OUT_READY = 1'b0;
                held = bus.O_DATA;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    checks++; if (bus.IN_READY !== 1'b0) $display("FAIL stall_in_ready: got %0b, required 0 (cycle %0d)", bus.IN_READY, k); else passes++;
                    checks++; if ({bus.OUT_VALID, bus.O_DATA} !== {1'b1, held})
                        $display("FAIL stall_hold: got valid=%0b data=%0d, required valid=1 data=%0d", bus.OUT_VALID, bus.O_DATA, held);
                    else passes++;
                end
                bus.OUT_READY = 1'b1;
            end
        join
        wait_drain(ok);
        checks++; if (!ok || out_cnt - c0 !== 6) $display("FAIL bp_count: got %0d outputs, required 6", out_cnt - c0); else passes++;
    endtask

    task automatic test_frame;
        int l0, d0;
        bit ok;
        l0 = last_cnt;
        d0 = done_cnt;
        out_w = 7'd3;
        out_h = 7'd2;
        start = 1'b1;
        @(negedge clk);
        checks++; if (bus.IN_READY !== 1'b0) $display("FAIL start_in_ready: got %0b, required 0", bus.IN_READY); else passes++;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++)
            send(8'(i * 13), 8'(255 - i), 8'(i * 3), 8'(100 + i), 4'(i), 4'(15 - i));
        wait_drain(ok);
        idle(2);
        checks++; if (!ok || last_cnt - l0 !== 2) $display("FAIL frame_last: got %0d, required 2", last_cnt - l0); else passes++;
        checks++; if (done_cnt - d0 !== 2) $display("FAIL frame_done: got %0d, required 2", done_cnt - d0); else passes++;
    endtask

    task automatic test_flush;
        int c0, l0, d0;
        bit ok;
        do_start(7'd2, 7'd2);
        send(8'd11, 8'd12, 8'd13, 8'd14, 4'd3, 4'd5);
        send(8'd21, 8'd22, 8'd23, 8'd24, 4'd6, 4'd2);
        wait_drain(ok);
        send(8'd31, 8'd32, 8'd33, 8'd34, 4'd1, 4'd1);
        send(8'd41, 8'd42, 8'd43, 8'd44, 4'd9, 4'd9);
        do_start(7'd2, 7'd2);
        c0 = out_cnt;
        idle(5);
        checks++; if (out_cnt - c0 !== 0) $display("FAIL flush_discard: got %0d outputs, required 0", out_cnt - c0); else passes++;
        l0 = last_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++)
            send(8'(50 + i), 8'(60 + i), 8'(70 + i), 8'(80 + i), 4'(2 * i), 4'(i));
        wait_drain(ok);
        idle(2);
        checks++; if (!ok || last_cnt - l0 !== 1) $display("FAIL flush_last: got %0d, required 1", last_cnt - l0); else passes++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL flush_done: got %0d, required 1", done_cnt - d0); else passes++;
    endtask

    task automatic test_zero_dims;
        int l0, d0;
        bit ok;
        do_start(7'd0, 7'd5);
        l0 = last_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++)
            send(8'(i), 8'(i), 8'(i), 8'(i), 4'd7, 4'd7);
        wait_drain(ok);
        idle(2);
        checks++; if (!ok || last_cnt - l0 !== 0) $display("FAIL zero_last: got %0d, required 0", last_cnt - l0); else passes++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL zero_done: got %0d, required 0", done_cnt - d0); else passes++;
    endtask

    task automatic test_random;
        int c0, l0;
        bit ok;
        do_start(7'd4, 7'd5);
        c0 = out_cnt;
        l0 = last_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        rand_ready = 1'b0;
        idle(1);
        bus.OUT_READY = 1'b1;
        wait_drain(ok);
        idle(2);
        checks++; if (!ok || out_cnt - c0 !== 20) $display("FAIL random_count: got %0d outputs, required 20", out_cnt - c0); else passes++;
        checks++; if (last_cnt - l0 !== 1) $display("FAIL random_last: got %0d, required 1", last_cnt - l0); else passes++;
    endtask

    task automatic test_async_reset;
        int c0;
        do_start(7'd3, 7'd2);
        send(8'd90, 8'd91, 8'd92, 8'd93, 4'd4, 4'd4);
        send(8'd94, 8'd95, 8'd96, 8'd97, 4'd4, 4'd4);
        send(8'd98, 8'd99, 8'd100, 8'd101, 4'd4, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.OUT_VALID !== 1'b0) $display("FAIL areset_out_valid: got %0b, required 0", bus.OUT_VALID); else passes++;
        checks++; if (bus.O_DATA !== 8'd0) $display("FAIL areset_o_data: got %0d, required 0", bus.O_DATA); else passes++;
        checks++; if (bus.OUT_LAST !== 1'b0) $display("FAIL areset_out_last: got %0b, required 0", bus.OUT_LAST); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL areset_done: got %0b, required 0", done); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = out_cnt;
        #1;
        checks++; if (bus.IN_READY !== 1'b1) $display("FAIL areset_in_ready: got %0b, required 1", bus.IN_READY); else passes++;
        idle(5);
        checks++; if (out_cnt - c0 !== 0) $display("FAIL areset_flush: got %0d outputs, required 0", out_cnt - c0); else passes++;
    endtask

    // Watchdog keeps the run bounded even if a handshake locks up.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_w = '0;
        out_h = '0;
        bus.IN_VALID = 1'b0;
        bus.P00 = '0; bus.P10 = '0; bus.P01 = '0; bus.P11 = '0;
        bus.FX = '0; bus.FY = '0;
        bus.OUT_READY = 1'b1;

        test_reset;
        test_identity_latency;
        test_vectors;
        test_back_to_back;
        test_backpressure;
        test_frame;
        test_flush;
        test_zero_dims;
        test_random;
        test_async_reset;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bilinear_pe.md
Name: bilinear_pe

Overview:
- Downstream arithmetic stage of the resize engine.
- Takes the four neighbour pixels and the 4-bit fractional offsets produced by the address/fetch stage, and computes one bilinear-interpolated output pixel.
- 3-stage pipeline with valid/ready handshake on both sides.
- Counts output pixels per frame, flags the last pixel and pulses DONE at frame end.

Parameters:
- DATA_W, 8: pixel width.
- FRAC_W, 4: fractional weight width; weights are in units of 1/2^FRAC_W.
- DIM_W, 7: width of the output-dimension fields (1..64 per axis).

Ports:
- clk  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse: latch OUT_W/OUT_H, flush pipeline, clear counter.
- OUT_W  in  DIM_W  output frame width in pixels; sampled on START.
- OUT_H  in  DIM_W  output frame height in pixels; sampled on START.
- IN_VALID  in  1  P00/P10/P01/P11/FX/FY valid.
- IN_READY  out  1  stage accepts input this cycle.
- P00  in  DATA_W  top-left pixel.
- P10  in  DATA_W  top-right pixel.
- P01  in  DATA_W  bottom-left pixel.
- P11  in  DATA_W  bottom-right pixel.
- FX  in  FRAC_W  horizontal fraction.
- FY  in  FRAC_W  vertical fraction.
- OUT_VALID  out  1  O_DATA valid.
- OUT_READY  in  1  downstream accepts O_DATA.
- O_DATA  out  DATA_W  interpolated pixel.
- OUT_LAST  out  1  qualifies O_DATA as the last pixel of the frame.
- DONE  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (RST_N low, async):
  - All stage valids, OUT_VALID, OUT_LAST and DONE go to 0; O_DATA = 0.
  - Pixel counter = 0; latched OUT_W/OUT_H = 0.
  - IN_READY = 1 after reset release.
- Global stall: advance = !OUT_VALID || OUT_READY; IN_READY = advance (combinational).
- All stage registers, including valid bits, load only when advance = 1. Bubbles are carried, not compressed.
- Input handshake: IN_VALID && IN_READY.
- Output handshake: OUT_VALID && OUT_READY.
- Latency: 3 cycles from input handshake to OUT_VALID when unstalled. Throughput: 1 pixel/cycle.
- Weights: WX0 = 2^FRAC_W - FX and WY0 = 2^FRAC_W - FY, each FRAC_W+1 bits (range 1..16).
- Stage 1: TOP = WX0*P00 + FX*P10 and BOT = WX0*P01 + FX*P11; DATA_W+FRAC_W bits, maximum 4080.
- Stage 2: V = WY0*TOP + FY*BOT; DATA_W+2*FRAC_W bits, maximum 65280.
- Stage 3: O_DATA = (V + 2^(2*FRAC_W-1)) >> 2*FRAC_W; rounding term as set by the optional feature.
  - Result is never above 2^DATA_W-1, so no clamp is needed.
  - Intermediates are sized so that nothing overflows.
- O_DATA and OUT_VALID are held stable while OUT_VALID && !OUT_READY.
- Pixel counter: 2*DIM_W bits; increments on each output handshake.
  - OUT_LAST = OUT_VALID && (counter == OUT_W*OUT_H - 1).
  - On the handshake with OUT_LAST = 1: counter clears to 0 and DONE is 1 in the following cycle, for exactly one cycle.
  - The next frame may stream back-to-back with no START.
- START:
  - Synchronous.
  - Clears all stage valids, counter, OUT_VALID and DONE in the next cycle; in-flight pixels are discarded.
  - IN_READY is forced to 0 during the START cycle.
  - START has priority over a simultaneous handshake, which is dropped.
- OUT_W = 0 or OUT_H = 0: product 0. OUT_LAST is never asserted, DONE never pulses, and the counter wraps modulo 2^(2*DIM_W).
- FX = 0 and FY = 0: O_DATA = P00 exactly, with or without rounding.

Optional Feature:
- Macro: BILERP_ROUND_EN.
- Defined: the stage-3 rounding constant 2^(2*FRAC_W-1) (128 with defaults) is added before the shift; round-half-up.
- Undefined: no constant is added; the result is truncated, V >> 2*FRAC_W. The adder is removed.
- Latency is 3 cycles in both cases.

Test Plan:
- Identity. FX=0, FY=0, P00=77, others 200 -> O_DATA=77 three cycles after the handshake, both builds.
- Midpoint. P00=0, P10=255, P01=0, P11=255, FX=8, FY=0 -> O_DATA=128 with BILERP_ROUND_EN, 127 without.
- Mixed weights. P00=10, P10=20, P01=30, P11=40, FX=4, FY=8 -> V=5760; O_DATA=23 with rounding, 22 without.
- Saturation corner. All pixels 255, FX=15, FY=15 -> O_DATA=255.
- Backpressure. Stream 6 pixels, hold OUT_READY=0 for 5 cycles after the first OUT_VALID:
  - IN_READY=0 and O_DATA is stable throughout the stall.
  - All 6 results emerge in order with no loss or duplication.
- Frame and flush.
  - START with OUT_W=3, OUT_H=2, then 6 inputs -> OUT_LAST only on the 6th output, DONE high one cycle after it.
  - START issued mid-stream with 2 pixels in flight -> no output from them, counter restarts at 0.
  - RST_N low mid-frame -> all outputs 0 immediately (async).
